// File: rtl/ysyx_23060229_lsu.sv
// Load/store unit: one transaction at a time over a req/gnt/rvalid bus,
// with store lane alignment and load byte/half extraction.
module ysyx_23060229_lsu #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [5:0] I_LB   = 6'd10,
    parameter logic [5:0] I_LH   = 6'd11,
    parameter logic [5:0] I_LW   = 6'd12,
    parameter logic [5:0] I_LBU  = 6'd13,
    parameter logic [5:0] I_LHU  = 6'd14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        typ,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [7:0]        mem_wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {K_NOP, K_LOAD, K_STORE} kind_t;

    state_t            r_state;
    state_t            w_state_next;
    kind_t             r_kind;
    kind_t             w_kind;
    logic [5:0]        r_typ;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_mask;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_capture;
    logic              w_half;
    logic              w_word;
    logic              w_misalign;
    logic              w_resp;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_ext;
    logic              w_unused_ok;

    assign w_unused_ok = ^mem_wmask[7:4];

    // A load wins when both enables are set (decoder's LHU encoding).
    always_comb begin
        w_kind = K_NOP;
        if (mem_ren) begin
            w_kind = K_LOAD;
        end else if (mem_wen) begin
            w_kind = K_STORE;
        end
    end

    assign w_half     = (typ == I_LH) || (typ == I_LHU) || (mem_wmask[3:0] == 4'b0011);
    assign w_word     = (typ == I_LW) || (mem_wmask[3:0] == 4'b1111);
    assign w_misalign = (w_kind != K_NOP) &&
                        ((w_half && addr[0]) || (w_word && (addr[1:0] != 2'b00)));

    assign w_capture  = in_valid && (r_state == S_IDLE);
    assign w_resp     = ((r_state == S_REQ) && bus_gnt && bus_rvalid) ||
                        ((r_state == S_WAIT) && bus_rvalid);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    if (w_kind != K_NOP && !w_misalign) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    w_state_next = bus_rvalid ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_shifted = bus_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (r_typ)
            I_LB:    w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            I_LBU:   w_load_ext = {24'd0, w_shifted[7:0]};
            I_LH:    w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            I_LHU:   w_load_ext = {16'd0, w_shifted[15:0]};
            I_LW:    w_load_ext = w_shifted;
            default: w_load_ext = w_shifted;
        endcase
    end

    // Misaligned ops are stored as NOP so they never drive the bus; r_err carries the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind  <= K_NOP;
            r_typ   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_kind  <= w_misalign ? K_NOP : w_kind;
            r_typ   <= typ;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_mask  <= mem_wmask[3:0];
            r_rdata <= '0;
            r_err   <= w_misalign;
        end else if (w_resp && r_kind == K_LOAD) begin
            r_rdata <= w_load_ext;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign bus_req   = (r_state == S_REQ);
    assign bus_we    = (r_kind == K_STORE);
    assign bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus_wdata = r_wdata << {r_addr[1:0], 3'b000};
    assign bus_wstrb = (r_kind == K_STORE) ? (r_mask << r_addr[1:0]) : 4'b0000;
    assign out_valid = (r_state == S_DONE);
    assign out_rdata = r_rdata;
    assign out_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060229_lsu.sv
// Directed bench for the LSU: stimulus pushes expected results into a queue,
// a monitor pops and compares on every write-back handshake.
module tb_ysyx_23060229_lsu;

    localparam logic [5:0] I_LB  = 6'd10;
    localparam logic [5:0] I_LH  = 6'd11;
    localparam logic [5:0] I_LW  = 6'd12;
    localparam logic [5:0] I_LBU = 6'd13;
    localparam logic [5:0] I_LHU = 6'd14;
    localparam logic [5:0] I_SH  = 6'd20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  typ = '0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [7:0]  mem_wmask = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rdata;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;
    exp_t exp_q[$];

    ysyx_23060229_lsu #(
        .ADDR_W(32), .DATA_W(32),
        .I_LB(I_LB), .I_LH(I_LH), .I_LW(I_LW), .I_LBU(I_LBU), .I_LHU(I_LHU)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .typ(typ), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
        .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] rd, input logic er, input int id);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.id    = id;
        exp_q.push_back(e);
    endtask

    // Presents one operation for a single cycle; returns 1ns after the capture edge (C+1).
    task automatic issue(input logic [5:0] t, input logic ren, input logic wen,
                         input logic [7:0] m, input logic [31:0] a, input logic [31:0] wd);
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        typ = t; mem_ren = ren; mem_wen = wen; mem_wmask = m; addr = a; wdata = wd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_wmask = '0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk(name, {31'd0, in_ready}, 32'd1);
    endtask

    // Single-cycle gnt+rvalid at C+1, then check out_valid at C+2.
    task automatic fast_load(input string name, input logic [31:0] rd);
        chk({name, "_req"}, {31'd0, bus_req}, 32'd1);
        chk({name, "_we"}, {31'd0, bus_we}, 32'd0);
        chk({name, "_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = rd;
        step();
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk({name, "_valid_c2"}, {31'd0, out_valid}, 32'd1);
        wait_idle({name, "_idle"});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 required=0 rdata=0x%08h", out_rdata);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("txn%0d_rdata", e.id), out_rdata, e.rdata);
                chk($sformatf("txn%0d_err", e.id), {31'd0, out_err}, {31'd0, e.err});
                $display("txn %0d rdata=0x%08h err=%0d", e.id, out_rdata, out_err);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // LW aligned
        push(32'hDEADBEEF, 1'b0, 1);
        issue(I_LW, 1'b1, 1'b0, 8'h0F, 32'h80000004, 32'h0);
        chk("lw_bus_addr", bus_addr, 32'h80000004);
        fast_load("lw", 32'hDEADBEEF);

        // LB / LBU at byte 3
        push(32'hFFFFFF80, 1'b0, 2);
        issue(I_LB, 1'b1, 1'b0, 8'h01, 32'h80000003, 32'h0);
        chk("lb_bus_addr", bus_addr, 32'h80000000);
        fast_load("lb", 32'h80112233);
        push(32'h00000080, 1'b0, 3);
        issue(I_LBU, 1'b1, 1'b0, 8'h01, 32'h80000003, 32'h0);
        fast_load("lbu", 32'h80112233);

        // SH with grant delayed 3 cycles, then response one cycle after grant
        push(32'h0, 1'b0, 4);
        issue(I_SH, 1'b0, 1'b1, 8'h03, 32'h80000002, 32'h0000ABCD);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sh_req_c%0d", i), {31'd0, bus_req}, 32'd1);
            chk($sformatf("sh_we_c%0d", i), {31'd0, bus_we}, 32'd1);
            chk($sformatf("sh_addr_c%0d", i), bus_addr, 32'h80000000);
            chk($sformatf("sh_wstrb_c%0d", i), {28'd0, bus_wstrb}, 32'hC);
            chk($sformatf("sh_wdata_c%0d", i), bus_wdata, 32'hABCD0000);
            if (i < 3) step();
        end
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        chk("sh_wait_req", {31'd0, bus_req}, 32'd0);
        chk("sh_wait_valid", {31'd0, out_valid}, 32'd0);
        bus_rvalid = 1'b1;
        step();
        bus_rvalid = 1'b0;
        chk("sh_done_valid", {31'd0, out_valid}, 32'd1);
        wait_idle("sh_idle");

        // LHU with both enables set
        push(32'h0000F00D, 1'b0, 5);
        issue(I_LHU, 1'b1, 1'b1, 8'h03, 32'h80000002, 32'h12345678);
        fast_load("lhu", 32'hF00D0000);

        // LH sign extension at offset 0
        push(32'hFFFF8001, 1'b0, 6);
        issue(I_LH, 1'b1, 1'b0, 8'h03, 32'h80000010, 32'h0);
        fast_load("lh", 32'h12348001);

        // Misaligned LW with write-back stalled
        out_ready = 1'b0;
        push(32'h0, 1'b1, 7);
        issue(I_LW, 1'b1, 1'b0, 8'h0F, 32'h80000001, 32'h0);
        chk("mis_valid_c1", {31'd0, out_valid}, 32'd1);
        chk("mis_req_c1", {31'd0, bus_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mis_hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("mis_hold_err_%0d", i), {31'd0, out_err}, 32'd1);
            chk($sformatf("mis_hold_rdata_%0d", i), out_rdata, 32'd0);
            chk($sformatf("mis_hold_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("mis_hold_req_%0d", i), {31'd0, bus_req}, 32'd0);
        end
        out_ready = 1'b1;
        wait_idle("mis_idle");

        // Misaligned SH (odd address) via mask
        push(32'h0, 1'b1, 8);
        issue(I_SH, 1'b0, 1'b1, 8'h03, 32'h80000003, 32'h1111);
        chk("missh_valid_c1", {31'd0, out_valid}, 32'd1);
        chk("missh_req_c1", {31'd0, bus_req}, 32'd0);
        wait_idle("missh_idle");

        // NOP
        push(32'h0, 1'b0, 9);
        issue(6'd1, 1'b0, 1'b0, 8'h00, 32'h80000001, 32'h0);
        chk("nop_valid_c1", {31'd0, out_valid}, 32'd1);
        chk("nop_req_c1", {31'd0, bus_req}, 32'd0);
        wait_idle("nop_idle");

        // Reset while waiting for a read response
        issue(I_LW, 1'b1, 1'b0, 8'h0F, 32'h80000008, 32'h0);
        chk("rstw_req", {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        chk("rstw_in_wait", {31'd0, bus_req | out_valid | in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstw_bus_addr", bus_addr, 32'd0);
        chk("rstw_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstw_out_rdata", out_rdata, 32'd0);
        step();
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        step();
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stale_valid_%0d", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("stale_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            step();
        end

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
